// File: rtl/branch_resolver.sv
// Branch resolver: captures one branch request, evaluates its condition and target,
// then holds a squash window after taken branches. Optional BR_MISALIGN_CHECK_EN.
module branch_resolver #(
  parameter int W            = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         br_valid,
  output logic         br_ready,
  input  logic [2:0]   br_funct,
  input  logic [W-1:0] rs1_val,
  input  logic [W-1:0] rs2_val,
  input  logic [W-1:0] br_pc,
  input  logic [W-1:0] br_imm,
  output logic         resolved_valid,
  output logic         take,
  output logic [W-1:0] target,
  output logic         flush,
  output logic         misalign,
  output logic [1:0]   state_dbg
);

  // Handshake: a request transfers on a rising edge where br_valid && br_ready.
  // br_ready is high only in IDLE; a requester must hold br_valid until then.
  typedef enum logic [1:0] {IDLE = 2'd0, RESOLVE = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t       state, state_next;
  logic [3:0]   flush_cnt, flush_cnt_next;
  logic [2:0]   funct_q;
  logic [W-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic         cond;
  logic         misalign_calc;
  logic         take_eff;
  logic [W-1:0] target_calc;

  always_comb begin
    cond = 1'b0;
    case (funct_q)
      3'b000:  cond = (rs1_q == rs2_q);
      3'b001:  cond = (rs1_q != rs2_q);
      3'b010:  cond = 1'b1;
      3'b011:  cond = 1'b0;
      3'b100:  cond = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101:  cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  cond = (rs1_q <  rs2_q);
      default: cond = (rs1_q >= rs2_q);
    endcase
  end

  assign target_calc = pc_q + imm_q;

`ifdef BR_MISALIGN_CHECK_EN
  assign misalign_calc = cond && (target_calc[1:0] != 2'b00);
`else
  assign misalign_calc = 1'b0;
`endif

  // A misaligned target suppresses the redirect and the flush window.
  assign take_eff = cond && !misalign_calc;

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      IDLE: begin
        if (br_valid) state_next = RESOLVE;
      end
      RESOLVE: begin
        if (take_eff && (FLUSH_LOAD != 4'd0)) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if (flush_cnt <= 4'd1) begin
          state_next     = IDLE;
          flush_cnt_next = 4'd0;
        end else begin
          flush_cnt_next = flush_cnt - 4'd1;
        end
      end
      default: begin
        state_next     = IDLE;
        flush_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_cnt      <= 4'd0;
      funct_q        <= 3'd0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      pc_q           <= '0;
      imm_q          <= '0;
      resolved_valid <= 1'b0;
      take           <= 1'b0;
      target         <= '0;
    end else begin
      state          <= state_next;
      flush_cnt      <= flush_cnt_next;
      resolved_valid <= (state == RESOLVE);
      take           <= (state == RESOLVE) && take_eff;
      if (state == IDLE && br_valid) begin
        funct_q <= br_funct;
        rs1_q   <= rs1_val;
        rs2_q   <= rs2_val;
        pc_q    <= br_pc;
        imm_q   <= br_imm;
      end
      if (state == RESOLVE) target <= target_calc;
    end
  end

`ifdef BR_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else        misalign <= (state == RESOLVE) && misalign_calc;
  end
`else
  assign misalign = 1'b0;
`endif

  assign br_ready  = (state == IDLE);
  assign flush     = (state == FLUSH);
  assign state_dbg = state;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed cases plus random requests checked
// against a reference model of the branch rules.
module tb_branch_resolver;
  localparam int W  = 32;
  localparam int FC = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         br_valid;
  logic         br_ready;
  logic [2:0]   br_funct;
  logic [W-1:0] rs1_val, rs2_val, br_pc, br_imm;
  logic         resolved_valid, take, flush, misalign;
  logic [W-1:0] target;
  logic [1:0]   state_dbg;

  branch_resolver #(.W(W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct(br_funct), .rs1_val(rs1_val), .rs2_val(rs2_val), .br_pc(br_pc),
    .br_imm(br_imm), .resolved_valid(resolved_valid), .take(take), .target(target),
    .flush(flush), .misalign(misalign), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_take_q[$];
  logic         exp_mis_q[$];
  int           exp_cyc_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model
  function automatic logic ref_cond(input logic [2:0] f, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return 1'b1;
      3'd3: return 1'b0;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      default: return a >= b;
    endcase
  endfunction

  // driver tasks
  task automatic send(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] p, input logic [W-1:0] i);
    bit done;
    logic c, m;
    logic [W-1:0] t;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      br_valid = 1'b1;
      br_funct = f;
      rs1_val  = a;
      rs2_val  = b;
      br_pc    = p;
      br_imm   = i;
      if (br_ready) begin
        c = ref_cond(f, a, b);
        t = p + i;
`ifdef BR_MISALIGN_CHECK_EN
        m = c && (t[1:0] != 2'b00);
`else
        m = 1'b0;
`endif
        exp_q.push_back(t);
        exp_take_q.push_back(c && !m);
        exp_mis_q.push_back(m);
        exp_cyc_q.push_back(cyc + 2);
        done = 1;
        @(posedge clk);
      end
    end
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    br_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // reset asserted away from both edges; drops any pending expectation
  task automatic pulse_reset(input int hold);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    br_valid = 1'b0;
    exp_q.delete();
    exp_take_q.delete();
    exp_mis_q.delete();
    exp_cyc_q.delete();
    #1;
    chk("rst_async_flush", 32'(flush), 32'd0);
    chk("rst_async_take", 32'(take), 32'd0);
    chk("rst_async_rv", 32'(resolved_valid), 32'd0);
    chk("rst_async_ready", 32'(br_ready), 32'd1);
    repeat (hold) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // scoreboard monitor
  int flush_rem = 0;
  logic [W-1:0] last_target = '0;
  initial begin
    logic [W-1:0] e_t;
    logic e_take, e_mis;
    int e_cyc;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        flush_rem = 0;
        last_target = '0;
        chk("in_reset_rv", 32'(resolved_valid), 32'd0);
        chk("in_reset_flush", 32'(flush), 32'd0);
        chk("in_reset_ready", 32'(br_ready), 32'd1);
        chk("in_reset_target", target, '0);
        continue;
      end
      chk("take_without_valid", 32'(take && !resolved_valid), 32'd0);
      if (resolved_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resolve", 32'(resolved_valid), 32'd0);
        end else begin
          e_t    = exp_q.pop_front();
          e_take = exp_take_q.pop_front();
          e_mis  = exp_mis_q.pop_front();
          e_cyc  = exp_cyc_q.pop_front();
          chk("take", 32'(take), 32'(e_take));
          chk("target", target, e_t);
          chk("misalign", 32'(misalign), 32'(e_mis));
          chk("latency_cycle", 32'(cyc), 32'(e_cyc));
          last_target = e_t;
          flush_rem = e_take ? FC : 0;
          chk("ready_at_resolve", 32'(br_ready), 32'(flush_rem == 0));
        end
      end else begin
        chk("target_stable", target, last_target);
        chk("misalign_idle", 32'(misalign), 32'd0);
        if (flush_rem > 0) chk("ready_in_flush", 32'(br_ready), 32'd0);
      end
      chk("flush", 32'(flush), 32'(flush_rem > 0));
      if (flush_rem > 0) flush_rem--;
    end
  end

  initial begin
    logic [2:0] f;
    logic [W-1:0] a, b, p, i;
    rst_n = 1'b0;
    br_valid = 1'b0;
    br_funct = 3'd0;
    rs1_val = '0;
    rs2_val = '0;
    br_pc = '0;
    br_imm = '0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ready", 32'(br_ready), 32'd1);
      chk("idle_take", 32'(take), 32'd0);
      chk("idle_flush", 32'(flush), 32'd0);
      chk("idle_target", target, '0);
    end

    send(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);            // BEQ taken
    idle(5);
    send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);    // BLT signed taken
    idle(4);
    send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h8);     // BLTU not taken
    send(3'b001, 32'd7, 32'd7, 32'h400, 32'hC);             // back-to-back BNE not taken
    idle(3);
    send(3'b010, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h20);      // JAL wraps
    idle(4);
    send(3'b000, 32'd9, 32'd9, 32'h100, 32'h6);             // misaligned target
    idle(4);
    send(3'b011, 32'd1, 32'd1, 32'h500, 32'h10);            // reserved, never taken
    idle(3);

    send(3'b001, 32'd1, 32'd2, 32'h600, 32'h10);            // reset mid-RESOLVE
    pulse_reset(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(br_ready), 32'd1);
      chk("post_rst_flush", 32'(flush), 32'd0);
    end

    send(3'b010, 32'd0, 32'd0, 32'h700, 32'h8);             // reset mid-FLUSH
    @(negedge clk);
    pulse_reset(1);
    idle(4);

    for (int k = 0; k < 60; k++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 2))
        0: b = a;
        1: b = a ^ 32'h1;
        default: b = $urandom;
      endcase
      p = {$urandom} & 32'hFFFF_FFFC;
      i = ($urandom_range(0, 3) == 0) ? $urandom : ({$urandom} & 32'hFFFF_FFFC);
      send(f, a, b, p, i);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(0);

    for (int n = 0; n < 50 && (exp_q.size() != 0 || flush_rem != 0); n++) @(negedge clk);
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
